// File: rtl/mem_slave_pkg.sv
// Shared types and helpers for the mem_slave_ws bus slave.
package mem_slave_pkg;

    typedef enum logic [1:0] {BYTE, HALF, WORD} tsize_t;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;

    localparam int unsigned MAX_WAIT_STATES = 15;

    function automatic logic [3:0] byte_en(tsize_t ts, logic [1:0] lane);
        case (ts)
            BYTE:    return 4'b0001 << lane;
            HALF:    return 4'b0011 << lane;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/slave_bus_if.sv
// System bus as seen by a slave: request in, registered response out.
interface slave_bus_if;
    import mem_slave_pkg::*;

    logic        bstart;
    logic        write;
    tsize_t      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        bdone;
    logic        berror;

    modport slave  (input bstart, write, tsize, addr, wdata,
                    output rdata, bdone, berror);
    modport master (output bstart, write, tsize, addr, wdata,
                    input rdata, bdone, berror);
endinterface

// File: rtl/mem_slave_array.sv
// N x 32 storage: byte-enable synchronous write, registered read (read-before-write).
module mem_slave_array #(
    parameter int unsigned N = 1024
) (
    input  logic                 clk,
    input  logic [3:0]           we,
    input  logic                 re,
    input  logic [$clog2(N)-1:0] idx,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);

    logic [31:0] mem [N];

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
        if (re) rdata <= mem[idx];
    end

endmodule

// File: rtl/mem_slave_ws.sv
// Memory bus slave with programmable wait states, byte-lane writes and read-only mode.
// Define MEM_SLAVE_BERR_EN to report access errors on berror.
module mem_slave_ws
    import mem_slave_pkg::*;
#(
    parameter int unsigned N           = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter int unsigned READ_ONLY   = 1
) (
    input  logic      clk,
    input  logic      rst,
    slave_bus_if.slave bus
);

    localparam int unsigned AW = $clog2(N);

    if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_n
        $error("mem_slave_ws: N must be a power of two and at least 4");
    end
    if (WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_ws
        $error("mem_slave_ws: WAIT_STATES must not exceed 15");
    end

    mem_state_t  state_q, state_d;
    logic [3:0]  cnt_q;
    logic        wr_q;
    tsize_t      ts_q;
    logic [31:0] addr_q, wdata_q;
    logic        err_q, zero_q;

    logic        accept, enter_done;
    logic        cur_wr;
    tsize_t      cur_ts;
    logic [31:0] cur_addr, cur_wdata;
    logic        misalign, oor, err;
    logic [3:0]  we;
    logic        re;
    logic [31:0] arr_rdata;

    // With zero wait states DONE is entered on the accept edge, so the
    // request is decoded straight from the bus rather than the latches.
    always_comb begin
        state_d   = state_q;
        accept    = bus.bstart && (state_q != BUSY);
        cur_wr    = accept ? bus.write : wr_q;
        cur_ts    = accept ? bus.tsize : ts_q;
        cur_addr  = accept ? bus.addr  : addr_q;
        cur_wdata = accept ? bus.wdata : wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = (WAIT_STATES == 0) ? DONE : BUSY;
                else        state_d = IDLE;
            end
            BUSY:    if (cnt_q == 4'd1) state_d = DONE;
            default: state_d = IDLE;
        endcase

        enter_done = (state_d == DONE) && !rst;
        misalign   = (cur_ts == HALF && cur_addr[0]) ||
                     (cur_ts == WORD && cur_addr[1:0] != 2'b00);
        oor        = cur_addr[31:AW+2] != '0;
        err        = misalign || oor || (cur_wr && READ_ONLY != 0);
        we         = (enter_done && cur_wr && !err) ? byte_en(cur_ts, cur_addr[1:0]) : '0;
        re         = enter_done && !err;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            ts_q    <= BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            if (accept) begin
                wr_q    <= bus.write;
                ts_q    <= bus.tsize;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                cnt_q   <= 4'(WAIT_STATES);
            end else if (state_q == BUSY) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (enter_done) begin
                err_q  <= err;
                zero_q <= err;
            end
        end
    end

    mem_slave_array #(.N(N)) u_array (
        .clk   (clk),
        .we    (we),
        .re    (re),
        .idx   (cur_addr[AW+1:2]),
        .wdata (cur_wdata),
        .rdata (arr_rdata)
    );

    // The array read register is not reset; zero_q masks it after reset and on errors.
    assign bus.rdata = zero_q ? '0 : arr_rdata;
    assign bus.bdone = (state_q == DONE);
`ifdef MEM_SLAVE_BERR_EN
    assign bus.berror = err_q;
`else
    assign bus.berror = 1'b0;
`endif

endmodule

// File: tb/tb_mem_slave_ws.sv
// Scoreboard bench for mem_slave_ws: a RAM instance (2 wait states) and a ROM instance (3 wait states).
module tb_mem_slave_ws;
    import mem_slave_pkg::*;

`ifdef MEM_SLAVE_BERR_EN
    localparam bit BERR = 1'b1;
`else
    localparam bit BERR = 1'b0;
`endif
    localparam int RAM_WS = 2;
    localparam int ROM_WS = 3;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        bit          chk_rd;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go_ram = 1'b0, go_rom = 1'b0;
    logic        s_write = 1'b0;
    tsize_t      s_tsize = WORD;
    logic [31:0] s_addr = '0, s_wdata = '0;

    int          errors = 0;
    int          checks = 0;
    exp_t        sb[$];
    logic [31:0] model [int];
    logic [31:0] rd;

    slave_bus_if ram_if();
    slave_bus_if rom_if();

    assign ram_if.bstart = go_ram;
    assign ram_if.write  = s_write;
    assign ram_if.tsize  = s_tsize;
    assign ram_if.addr   = s_addr;
    assign ram_if.wdata  = s_wdata;
    assign rom_if.bstart = go_rom;
    assign rom_if.write  = s_write;
    assign rom_if.tsize  = s_tsize;
    assign rom_if.addr   = s_addr;
    assign rom_if.wdata  = s_wdata;

    mem_slave_ws #(.N(1024), .WAIT_STATES(RAM_WS), .READ_ONLY(0)) u_ram (
        .clk (clk), .rst (rst), .bus (ram_if));
    mem_slave_ws #(.N(1024), .WAIT_STATES(ROM_WS), .READ_ONLY(1)) u_rom (
        .clk (clk), .rst (rst), .bus (rom_if));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One transaction: expectation pushed at drive time, popped at bdone.
    task automatic issue(input string tag, input bit rom, input bit wr, input tsize_t ts,
                         input logic [31:0] a, input logic [31:0] d, output logic [31:0] got);
        exp_t        e;
        exp_t        o;
        int          lat;
        logic        mis, oor, err;
        logic [31:0] m;
        int          k;
        k   = int'(a[11:2]);
        mis = (ts == HALF && a[0]) || (ts == WORD && a[1:0] != 2'b00);
        oor = a >= 32'h1000;
        err = mis || oor || (wr && rom);
        e.err    = err && BERR;
        e.chk_rd = err || (!rom && !wr);
        e.rd     = (err || !model.exists(k)) ? 32'h0 : model[k];
        if (!rom && wr && !err) begin
            case (ts)
                BYTE:    m = 32'h0000_00FF << (8 * a[1:0]);
                HALF:    m = 32'h0000_FFFF << (8 * a[1:0]);
                default: m = 32'hFFFF_FFFF;
            endcase
            model[k] = ((model.exists(k) ? model[k] : 32'h0) & ~m) | (d & m);
        end
        sb.push_back(e);

        @(negedge clk);
        s_write = wr; s_tsize = ts; s_addr = a; s_wdata = d;
        if (rom) go_rom = 1'b1; else go_ram = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go_rom = 1'b0; go_ram = 1'b0;
        lat = 0;
        while (!(rom ? rom_if.bdone : ram_if.bdone) && lat < 20) begin
            if (rom && lat == 1) go_rom = 1'b1;
            if (rom && lat == 2) go_rom = 1'b0;
            @(negedge clk);
            lat++;
        end
        go_rom = 1'b0;
        check({tag, "/latency"}, lat, rom ? ROM_WS : RAM_WS);
        got = rom ? rom_if.rdata : ram_if.rdata;
        o = sb.pop_front();
        if (o.chk_rd) check({tag, "/rdata"}, got, o.rd);
        check({tag, "/berror"}, {31'b0, rom ? rom_if.berror : ram_if.berror}, {31'b0, o.err});
        @(negedge clk);
        check({tag, "/bdone_pulse"}, {31'b0, rom ? rom_if.bdone : ram_if.bdone}, 32'h0);
    endtask

    task automatic back_to_back();
        exp_t e;
        exp_t o;
        int   p, cyc, nd, last;
        bit   adv;
        for (int i = 0; i < 4; i++) begin
            e.rd = model[64 + i]; e.err = 1'b0; e.chk_rd = 1'b1;
            sb.push_back(e);
        end
        @(negedge clk);
        s_write = 1'b0; s_tsize = WORD; s_addr = 32'h100; go_ram = 1'b1;
        @(posedge clk);
        @(negedge clk);
        p = 1; s_addr = 32'h104;
        cyc = 0; nd = 0; last = 0; adv = 1'b0;
        while (nd < 4 && cyc < 40) begin
            if (adv) begin
                p++;
                s_addr = 32'h100 + 32'(4 * p);
                adv = 1'b0;
            end
            if (ram_if.bdone) begin
                nd++;
                o = sb.pop_front();
                check("b2b/rdata", ram_if.rdata, o.rd);
                check("b2b/berror", {31'b0, ram_if.berror}, 32'h0);
                if (nd == 1) check("b2b/first", cyc, RAM_WS);
                else         check("b2b/gap", cyc - last, RAM_WS + 1);
                last = cyc;
                if (nd == 4) go_ram = 1'b0;
                else         adv = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        go_ram = 1'b0;
        check("b2b/count", nd, 4);
        check("b2b/end", {31'b0, ram_if.bdone}, 32'h0);
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst/ram_rdata",  ram_if.rdata, 32'h0);
        check("rst/ram_bdone",  {31'b0, ram_if.bdone}, 32'h0);
        check("rst/ram_berror", {31'b0, ram_if.berror}, 32'h0);
        check("rst/rom_rdata",  rom_if.rdata, 32'h0);
        check("rst/rom_bdone",  {31'b0, rom_if.bdone}, 32'h0);
        check("rst/rom_berror", {31'b0, rom_if.berror}, 32'h0);

        issue("wr_word",  0, 1, WORD, 32'h10, 32'hDEAD_BEEF, rd);
        issue("rd_word",  0, 0, WORD, 32'h10, 32'h0, rd);

        issue("lane_pre", 0, 1, WORD, 32'h20, 32'h0000_0000, rd);
        issue("lane_b",   0, 1, BYTE, 32'h22, 32'h00AB_0000, rd);
        issue("lane_h",   0, 1, HALF, 32'h20, 32'h0000_1234, rd);
        issue("lane_rd",  0, 0, WORD, 32'h20, 32'h0, rd);
        issue("lane_b0",  0, 1, BYTE, 32'h23, 32'h7700_0000, rd);
        issue("lane_rd2", 0, 0, BYTE, 32'h21, 32'h0, rd);

        issue("err_pre",  0, 1, WORD, 32'h0,    32'h0BAD_F00D, rd);
        issue("err_mis",  0, 0, WORD, 32'h2,    32'h0, rd);
        issue("err_misw", 0, 1, WORD, 32'h2,    32'hFFFF_FFFF, rd);
        issue("err_mish", 0, 1, HALF, 32'h1,    32'h1111_1111, rd);
        issue("err_oor",  0, 0, WORD, 32'h1000, 32'h0, rd);
        issue("err_oorw", 0, 1, WORD, 32'h1000, 32'h2222_2222, rd);
        issue("err_chk",  0, 0, WORD, 32'h0,    32'h0, rd);
        issue("ok_after", 0, 0, WORD, 32'h10,   32'h0, rd);

        issue("rom_rd",   1, 0, WORD, 32'h40, 32'h0, rd);
        issue("rom_wr",   1, 1, WORD, 32'h40, 32'hA5A5_5A5A, rd);
        issue("rom_rd2",  1, 0, WORD, 32'h40, 32'h0, rd);
        check("rom_unwritten", {31'b0, rd == 32'hA5A5_5A5A}, 32'h0);

        for (int i = 0; i < 4; i++)
            issue("b2b_pre", 0, 1, WORD, 32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 17), rd);
        back_to_back();

        issue("rst_pre",  0, 1, WORD, 32'h30, 32'h1111_2222, rd);
        @(negedge clk);
        s_write = 1'b1; s_tsize = WORD; s_addr = 32'h30; s_wdata = 32'h0000_0055; go_ram = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go_ram = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst/rdata",  ram_if.rdata, 32'h0);
        check("midrst/berror", {31'b0, ram_if.berror}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            check("midrst/bdone", {31'b0, ram_if.bdone}, 32'h0);
            @(negedge clk);
        end
        issue("midrst_rd", 0, 0, WORD, 32'h30, 32'h0, rd);

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
